// File: rtl/usb_protocol_ctrl.sv
// usb_protocol_ctrl: endpoint protocol sequencer between usb_rx and usb_tx.
// Picks the handshake reply and tracks OUT/IN transfer status flags.
`timescale 1ns/1ps
module usb_protocol_ctrl #(
   parameter int BUF_DEPTH      = 64,
   parameter int TIMEOUT_CYCLES = 128
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [2:0] rx_packet,
   input  logic       store_rx_packet_data,
   input  logic [6:0] buffer_occupancy,
   input  logic [6:0] tx_data_size,
   input  logic       tx_done,
   output logic [1:0] tx_packet,
   output logic       tx_start,
   output logic       flush_buffer,
   output logic       rx_data_ready,
   output logic       rx_transfer_active,
   output logic       tx_transfer_active,
   output logic       rx_error,
   output logic       tx_error,
   output logic       tx_complete
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [2:0] RX_IN    = 3'b001;
   localparam logic [2:0] RX_OUT   = 3'b010;
   localparam logic [2:0] RX_ACK   = 3'b011;
   localparam logic [2:0] RX_ERR   = 3'b100;
   localparam logic [2:0] RX_DONE  = 3'b101;
   localparam logic [2:0] RX_DATA0 = 3'b110;
   localparam logic [2:0] RX_NAK   = 3'b111;

   localparam logic [1:0] TX_NONE  = 2'b00;
   localparam logic [1:0] TX_DATA0 = 2'b01;
   localparam logic [1:0] TX_ACK   = 2'b10;
   localparam logic [1:0] TX_NAK   = 2'b11;

   typedef enum logic [2:0] {
      IDLE, OUT_WAIT, DATA_WAIT, RX_DATA,
      IN_WAIT, SEND, HACK_WAIT, ACK_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [2:0]    prev_q;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [6:0]    cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic          out_q, out_d;
   logic [1:0]    pkt_q, pkt_d;
   logic          start_q, start_d;
   logic          flush_q, flush_d;
   logic          rdy_q, rdy_d;
   logic          rxe_q, rxe_d;
   logic          txe_q, txe_d;
   logic          cmpl_q, cmpl_d;
   logic          evt, tmo_exp;

   // Held codes act once: only a change of rx_packet is an event.
   assign evt     = (rx_packet != prev_q);
   assign tmo_exp = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d = state_q;
      tmo_d   = '0;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      out_d   = out_q;
      pkt_d   = pkt_q;
      start_d = 1'b0;
      flush_d = 1'b0;
      rdy_d   = rdy_q;
      rxe_d   = rxe_q;
      txe_d   = txe_q;
      cmpl_d  = 1'b0;
      // A store coincident with DONE/ERROR is counted before the decision.
      if (state_q == RX_DATA && store_rx_packet_data) begin
         if (cnt_q != 7'h7f) cnt_d = cnt_q + 7'd1;
         if (buffer_occupancy == 7'(BUF_DEPTH)) ovf_d = 1'b1;
      end
      unique case (state_q)
         IDLE: begin
            if (evt && rx_packet == RX_OUT) begin
               state_d = OUT_WAIT;
               out_d   = 1'b1;
               rdy_d   = 1'b0;
               rxe_d   = 1'b0;
            end else if (evt && rx_packet == RX_IN) begin
               state_d = IN_WAIT;
               out_d   = 1'b0;
               txe_d   = 1'b0;
            end
         end
         OUT_WAIT: begin
            if (evt && rx_packet == RX_DONE) begin
               state_d = DATA_WAIT;
            end else if (evt && rx_packet == RX_ERR) begin
               state_d = IDLE;
               rxe_d   = 1'b1;
            end
         end
         DATA_WAIT: begin
            if (evt && rx_packet == RX_DATA0) begin
               state_d = RX_DATA;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end else if ((evt && rx_packet == RX_ERR) || tmo_exp) begin
               state_d = IDLE;
               rxe_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (evt && rx_packet == RX_DONE) begin
               state_d = SEND;
               start_d = 1'b1;
               if (!ovf_d && cnt_d >= 7'd2) begin
                  pkt_d = TX_ACK;
               end else begin
                  pkt_d   = TX_NAK;
                  flush_d = 1'b1;
               end
            end else if (evt && rx_packet == RX_ERR) begin
               state_d = IDLE;
               rxe_d   = 1'b1;
               flush_d = 1'b1;
            end
         end
         IN_WAIT: begin
            if (evt && rx_packet == RX_DONE) begin
               state_d = SEND;
               start_d = 1'b1;
               if (tx_data_size != '0 && buffer_occupancy >= tx_data_size)
                  pkt_d = TX_DATA0;
               else
                  pkt_d = TX_NAK;
            end else if (evt && rx_packet == RX_ERR) begin
               state_d = IDLE;
               txe_d   = 1'b1;
            end
         end
         SEND: begin
            if (tx_done) begin
               pkt_d   = TX_NONE;
               state_d = (pkt_q == TX_DATA0) ? HACK_WAIT : IDLE;
               if (pkt_q == TX_ACK) rdy_d = 1'b1;
            end
         end
         HACK_WAIT: begin
            if (evt && rx_packet == RX_ACK) begin
               state_d = ACK_DONE;
            end else if ((evt && (rx_packet == RX_NAK || rx_packet == RX_ERR))
                         || tmo_exp) begin
               state_d = IDLE;
               txe_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         ACK_DONE: begin
            if (evt && rx_packet == RX_DONE) begin
               state_d = IDLE;
               cmpl_d  = 1'b1;
            end else if (evt && rx_packet == RX_ERR) begin
               state_d = IDLE;
               txe_d   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= IDLE;
         prev_q  <= 3'b000;
         tmo_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         out_q   <= 1'b0;
         pkt_q   <= TX_NONE;
         start_q <= 1'b0;
         flush_q <= 1'b0;
         rdy_q   <= 1'b0;
         rxe_q   <= 1'b0;
         txe_q   <= 1'b0;
         cmpl_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         prev_q  <= rx_packet;
         tmo_q   <= tmo_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         out_q   <= out_d;
         pkt_q   <= pkt_d;
         start_q <= start_d;
         flush_q <= flush_d;
         rdy_q   <= rdy_d;
         rxe_q   <= rxe_d;
         txe_q   <= txe_d;
         cmpl_q  <= cmpl_d;
      end
   end

   assign tx_packet     = pkt_q;
   assign tx_start      = start_q;
   assign flush_buffer  = flush_q;
   assign rx_data_ready = rdy_q;
   assign rx_error      = rxe_q;
   assign tx_error      = txe_q;
   assign tx_complete   = cmpl_q;

   assign rx_transfer_active = (state_q == OUT_WAIT) || (state_q == DATA_WAIT)
                            || (state_q == RX_DATA) || (state_q == SEND && out_q);
   assign tx_transfer_active = (state_q == IN_WAIT) || (state_q == HACK_WAIT)
                            || (state_q == SEND && !out_q);
endmodule

// File: tb/tb_usb_protocol_ctrl.sv
// tb_usb_protocol_ctrl: directed transfers against a transaction-level
// model of the endpoint sequencer, compared every clock.
`timescale 1ns/1ps
module tb_usb_protocol_ctrl;
   localparam int TMO = 128;
   localparam logic [2:0] C_NONE = 3'd0, C_IN = 3'd1, C_OUT = 3'd2;
   localparam logic [2:0] C_ACK = 3'd3, C_ERR = 3'd4, C_DONE = 3'd5;
   localparam logic [2:0] C_DATA0 = 3'd6, C_NAK = 3'd7;
   localparam int PH_IDLE = 0, PH_OUTTOK = 1, PH_WDATA = 2, PH_RECV = 3;
   localparam int PH_INTOK = 4, PH_REPLY = 5, PH_HACK = 6, PH_ACKED = 7;

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   logic [2:0] rx_packet = 3'd0;
   logic store_rx_packet_data = 1'b0;
   logic [6:0] buffer_occupancy = 7'd0;
   logic [6:0] tx_data_size = 7'd0;
   logic tx_done = 1'b0;
   logic [1:0] tx_packet;
   logic tx_start, flush_buffer, rx_data_ready;
   logic rx_transfer_active, tx_transfer_active;
   logic rx_error, tx_error, tx_complete;

   int checks = 0;
   int errors = 0;
   int n_start = 0, n_flush = 0, n_cmpl = 0;

   usb_protocol_ctrl dut (
      .clk(clk), .n_rst(n_rst), .rx_packet(rx_packet),
      .store_rx_packet_data(store_rx_packet_data),
      .buffer_occupancy(buffer_occupancy), .tx_data_size(tx_data_size),
      .tx_done(tx_done), .tx_packet(tx_packet), .tx_start(tx_start),
      .flush_buffer(flush_buffer), .rx_data_ready(rx_data_ready),
      .rx_transfer_active(rx_transfer_active),
      .tx_transfer_active(tx_transfer_active),
      .rx_error(rx_error), .tx_error(tx_error), .tx_complete(tx_complete)
   );

   always #5 clk = ~clk;

   // Transaction-level model: phase of the transfer plus timestamps.
   int ph, m_bytes, cyc, t_enter;
   bit m_out, m_ovf, ev, late;
   logic [2:0] m_prev, c;
   logic [1:0] m_pkt;
   bit m_start, m_flush, m_rdy, m_rxe, m_txe, m_cmpl;

   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         ph = PH_IDLE; m_out = 0; m_bytes = 0; m_ovf = 0;
         cyc = 0; t_enter = 0; m_prev = 3'd0; m_pkt = 2'd0;
         m_start = 0; m_flush = 0; m_rdy = 0;
         m_rxe = 0; m_txe = 0; m_cmpl = 0;
      end else begin
         cyc = cyc + 1;
         c = rx_packet;
         ev = (c != m_prev);
         m_prev = c;
         m_start = 0; m_flush = 0; m_cmpl = 0;
         late = (cyc - t_enter >= TMO);
         if (ph == PH_RECV && store_rx_packet_data) begin
            if (m_bytes < 127) m_bytes = m_bytes + 1;
            if (buffer_occupancy == 7'd64) m_ovf = 1;
         end
         case (ph)
            PH_IDLE:
               if (ev && c == C_OUT) begin
                  ph = PH_OUTTOK; m_out = 1; m_rdy = 0; m_rxe = 0;
               end else if (ev && c == C_IN) begin
                  ph = PH_INTOK; m_out = 0; m_txe = 0;
               end
            PH_OUTTOK:
               if (ev && c == C_DONE) begin
                  ph = PH_WDATA; t_enter = cyc;
               end else if (ev && c == C_ERR) begin
                  ph = PH_IDLE; m_rxe = 1;
               end
            PH_WDATA:
               if (ev && c == C_DATA0) begin
                  ph = PH_RECV; m_bytes = 0; m_ovf = 0;
               end else if ((ev && c == C_ERR) || late) begin
                  ph = PH_IDLE; m_rxe = 1;
               end
            PH_RECV:
               if (ev && c == C_DONE) begin
                  ph = PH_REPLY; m_start = 1;
                  if (!m_ovf && m_bytes >= 2) m_pkt = 2'b10;
                  else begin m_pkt = 2'b11; m_flush = 1; end
               end else if (ev && c == C_ERR) begin
                  ph = PH_IDLE; m_rxe = 1; m_flush = 1;
               end
            PH_INTOK:
               if (ev && c == C_DONE) begin
                  ph = PH_REPLY; m_start = 1;
                  if (int'(tx_data_size) > 0 &&
                      int'(buffer_occupancy) >= int'(tx_data_size))
                     m_pkt = 2'b01;
                  else
                     m_pkt = 2'b11;
               end else if (ev && c == C_ERR) begin
                  ph = PH_IDLE; m_txe = 1;
               end
            PH_REPLY:
               if (tx_done) begin
                  if (m_pkt == 2'b10) m_rdy = 1;
                  if (m_pkt == 2'b01) begin
                     ph = PH_HACK; t_enter = cyc;
                  end else ph = PH_IDLE;
                  m_pkt = 2'b00;
               end
            PH_HACK:
               if (ev && c == C_ACK) ph = PH_ACKED;
               else if ((ev && (c == C_NAK || c == C_ERR)) || late) begin
                  ph = PH_IDLE; m_txe = 1;
               end
            PH_ACKED:
               if (ev && c == C_DONE) begin
                  ph = PH_IDLE; m_cmpl = 1;
               end else if (ev && c == C_ERR) begin
                  ph = PH_IDLE; m_txe = 1;
               end
            default: ph = PH_IDLE;
         endcase
      end
   end

   wire [9:0] dut_vec = {tx_packet, tx_start, flush_buffer, rx_data_ready,
                         rx_transfer_active, tx_transfer_active,
                         rx_error, tx_error, tx_complete};
   logic [9:0] mdl_vec;
   always_comb begin
      mdl_vec = {m_pkt, m_start, m_flush, m_rdy,
                 (ph == PH_OUTTOK || ph == PH_WDATA || ph == PH_RECV ||
                  (ph == PH_REPLY && m_out)),
                 (ph == PH_INTOK || ph == PH_HACK ||
                  (ph == PH_REPLY && !m_out)),
                 m_rxe, m_txe, m_cmpl};
   end

   always @(negedge clk) begin
      if (n_rst) begin
         checks++;
         if (dut_vec !== mdl_vec) begin
            errors++;
            $display("FAIL model_cmp t=%0t got %b expected %b",
                     $time, dut_vec, mdl_vec);
         end
         if (tx_start) n_start++;
         if (flush_buffer) n_flush++;
         if (tx_complete) n_cmpl++;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic code(input logic [2:0] v);
      rx_packet = v;
      @(negedge clk);
   endtask

   task automatic store(input logic [6:0] occ);
      buffer_occupancy = occ;
      store_rx_packet_data = 1'b1;
      @(negedge clk);
      store_rx_packet_data = 1'b0;
      @(negedge clk);
   endtask

   task automatic serve_tx(output logic [1:0] pkt, output int lat);
      bit got;
      got = 0; pkt = 2'b00; lat = -1;
      for (int i = 0; i < 20 && !got; i++) begin
         if (tx_start) begin
            got = 1; pkt = tx_packet; lat = i;
         end else @(negedge clk);
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL tx_start_wait: got none in 20 cycles expected 1");
      end else begin
         repeat (3) @(negedge clk);
         tx_done = 1'b1;
         @(negedge clk);
         tx_done = 1'b0;
      end
   endtask

   task automatic out_xfer(input int n, input logic [6:0] occ0,
                           output logic [1:0] pkt, output int lat);
      code(C_NONE); code(C_OUT); code(C_DONE); code(C_DATA0);
      for (int i = 0; i < n; i++) store(i == 0 ? occ0 : 7'(i));
      code(C_DONE);
      serve_tx(pkt, lat);
   endtask

   task automatic in_xfer(input logic [6:0] sz, input logic [6:0] occ,
                          output logic [1:0] pkt);
      int lat;
      tx_data_size = sz;
      buffer_occupancy = occ;
      code(C_NONE); code(C_IN); code(C_DONE);
      serve_tx(pkt, lat);
      chk("in_latency", lat, 0);
   endtask

   logic [1:0] pkt;
   int lat, s0, f0, c0;

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_outputs", dut_vec, 0);
      n_rst = 1'b1;
      @(negedge clk);

      s0 = n_start;
      out_xfer(4, 7'd0, pkt, lat);
      chk("out_ack_pkt", pkt, 2'b10);
      chk("out_ack_latency", lat, 0);
      chk("out_ack_rdy", rx_data_ready, 1);
      chk("out_ack_rxerr", rx_error, 0);
      chk("out_ack_active", rx_transfer_active, 0);
      chk("out_ack_starts", n_start - s0, 1);

      f0 = n_flush;
      out_xfer(4, 7'd64, pkt, lat);
      chk("out_ovf_pkt", pkt, 2'b11);
      chk("out_ovf_flush", n_flush - f0, 1);
      chk("out_ovf_rdy", rx_data_ready, 0);

      f0 = n_flush;
      out_xfer(1, 7'd0, pkt, lat);
      chk("out_short_pkt", pkt, 2'b11);
      chk("out_short_flush", n_flush - f0, 1);
      out_xfer(2, 7'd63, pkt, lat);
      chk("out_two_pkt", pkt, 2'b10);

      in_xfer(7'd8, 7'd8, pkt);
      chk("in_data0_pkt", pkt, 2'b01);
      chk("in_hack_active", tx_transfer_active, 1);
      c0 = n_cmpl;
      code(C_ACK); code(C_DONE);
      @(negedge clk);
      chk("in_complete", n_cmpl - c0, 1);
      chk("in_txerr", tx_error, 0);

      in_xfer(7'd0, 7'd8, pkt);
      chk("in_size0_pkt", pkt, 2'b11);
      in_xfer(7'd8, 7'd7, pkt);
      chk("in_short_pkt", pkt, 2'b11);
      chk("in_nak_txerr", tx_error, 0);

      c0 = n_cmpl;
      in_xfer(7'd8, 7'd8, pkt);
      chk("in_tmo_pkt", pkt, 2'b01);
      repeat (TMO - 2) @(negedge clk);
      chk("in_tmo_early", tx_transfer_active, 1);
      repeat (5) @(negedge clk);
      chk("in_tmo_txerr", tx_error, 1);
      chk("in_tmo_active", tx_transfer_active, 0);
      chk("in_tmo_cmpl", n_cmpl - c0, 0);

      s0 = n_start;
      code(C_NONE); code(C_OUT); code(C_DONE); code(C_NONE);
      repeat (TMO + 5) @(negedge clk);
      chk("out_tmo_rxerr", rx_error, 1);
      chk("out_tmo_active", rx_transfer_active, 0);
      chk("out_tmo_starts", n_start - s0, 0);

      f0 = n_flush;
      code(C_OUT); code(C_DONE); code(C_DATA0);
      store(7'd0); store(7'd1);
      code(C_ERR);
      repeat (10) @(negedge clk);
      chk("out_err_flush", n_flush - f0, 1);
      chk("out_err_rxerr", rx_error, 1);
      chk("out_err_starts", n_start - s0, 0);

      s0 = n_start;
      code(C_NONE); code(C_OUT); code(C_DONE); code(C_DATA0);
      store(7'd0); store(7'd1); store(7'd2);
      code(C_DONE);
      chk("rst_send_start", tx_start, 1);
      #2 n_rst = 1'b0;
      #1 chk("rst_send_outputs", dut_vec, 0);
      rx_packet = C_NONE;
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      out_xfer(4, 7'd0, pkt, lat);
      chk("rst_send_next_pkt", pkt, 2'b10);
      chk("rst_send_next_rdy", rx_data_ready, 1);
      chk("rst_send_starts", n_start - s0, 2);

      in_xfer(7'd4, 7'd10, pkt);
      chk("rst_hack_pkt", pkt, 2'b01);
      repeat (5) @(negedge clk);
      chk("rst_hack_active", tx_transfer_active, 1);
      #2 n_rst = 1'b0;
      #1 chk("rst_hack_outputs", dut_vec, 0);
      rx_packet = C_NONE;
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      out_xfer(3, 7'd0, pkt, lat);
      chk("rst_hack_next_pkt", pkt, 2'b10);
      chk("rst_hack_next_txerr", tx_error, 0);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
